// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the shared single-port multi-cycle memory.
// Define MEM_ARB_PERF_EN to add saturating grant/stall perf counters.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_if_grants,
  output logic [15:0]       perf_d_grants,
  output logic [15:0]       perf_stall_cyc
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [SW-1:0] starveCnt;
  logic          dFirst;
  logic          grantIf;
  logic          grantD;
  logic          busy;
  logic          finish;

  // Data wins unless it has starved a pending fetch for too long.
  always_comb begin
    dFirst  = d_req && (starveCnt < SMAX);
    grantD  = 1'b0;
    grantIf = 1'b0;
    if (state == IDLE) begin
      grantD  = dFirst || (!if_req && d_req);
      grantIf = !dFirst && if_req;
    end
  end

  assign busy   = (state == FETCH) || (state == DATA);
  assign finish = busy && mem_valid;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grantD:  nxt = DATA;
          grantIf: nxt = FETCH;
          default: nxt = IDLE;
        endcase
      end
      FETCH,
      DATA: begin
        if (mem_valid) begin
          nxt = DONE;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grantD) begin
      mem_en    <= 1'b1;
      mem_wr    <= d_wr;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (grantIf) begin
      mem_en    <= 1'b1;
      mem_wr    <= 1'b0;
      mem_addr  <= if_addr;
    end else if (finish) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      if (finish && state == FETCH) begin
        if_rdata <= mem_rdata;
        if_done  <= 1'b1;
      end
      if (finish && state == DATA) begin
        d_rdata <= mem_rdata;
        d_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (state == IDLE) begin
      if (!if_req || grantIf) begin
        starveCnt <= '0;
      end else if (grantD && starveCnt < SMAX) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic ifStall;
  logic dStall;

  // A port is stalled while it requests but is neither granted,
  // in service, nor receiving its done pulse.
  assign ifStall = if_req && !if_done &&
                   (state != FETCH) && !grantIf;
  assign dStall  = d_req && !d_done &&
                   (state != DATA) && !grantD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_grants <= '0;
      perf_d_grants  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (grantIf && perf_if_grants != 16'hFFFF) begin
        perf_if_grants <= perf_if_grants + 16'd1;
      end
      if (grantD && perf_d_grants != 16'hFFFF) begin
        perf_d_grants <= perf_d_grants + 16'd1;
      end
      if ((ifStall || dStall) &&
          perf_stall_cyc != 16'hFFFF) begin
        perf_stall_cyc <= perf_stall_cyc + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 3-cycle memory model.
// Build with MEM_ARB_PERF_EN to also check the perf counters.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_grants;
  logic [15:0] perf_d_grants;
  logic [15:0] perf_stall_cyc;
`endif

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  // memory model: word[a] = a ^ A5A5, completes on 3rd enabled cycle
  logic [15:0] mem [0:65535];
  logic [1:0]  lat = 2'd0;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'(i) ^ 16'hA5A5;
    end
  end

  assign mem_valid = mem_en && (lat == 2'd2);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_en) begin
      lat <= 2'd0;
    end else if (lat == 2'd2) begin
      lat <= 2'd0;
      if (mem_wr) begin
        mem[mem_addr] <= mem_wdata;
      end
    end else begin
      lat <= lat + 2'd1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        chk;
    logic [15:0] v;
  } exp_t;

  exp_t        dq[$];
  exp_t        iq[$];
  logic [31:0] seqBits = '0;
  int          seqLen  = 0;
  int          enCnt   = 0;
  logic        wrSeen  = 1'b0;
  logic        dPrev   = 1'b0;
  logic        iPrev   = 1'b0;

  // monitor: pops expectations whenever a done pulse appears
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      enCnt  = 0;
      wrSeen = 1'b0;
    end else begin
      if (d_done) begin
        check("d_done_width", 32'(dPrev), 32'd0);
        check("d_en_cycles", 32'(enCnt), 32'd3);
        if (dq.size() == 0) begin
          check("d_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = dq.pop_front();
          if (e.chk) check("d_rdata", 32'(d_rdata), 32'(e.v));
        end
        seqBits = {seqBits[30:0], 1'b1};
        seqLen++;
      end
      if (if_done) begin
        check("if_done_width", 32'(iPrev), 32'd0);
        check("if_en_cycles", 32'(enCnt), 32'd3);
        check("if_mem_wr", 32'(wrSeen), 32'd0);
        if (iq.size() == 0) begin
          check("if_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = iq.pop_front();
          if (e.chk) check("if_rdata", 32'(if_rdata), 32'(e.v));
        end
        seqBits = {seqBits[30:0], 1'b0};
        seqLen++;
      end
      if (mem_en) begin
        enCnt++;
        wrSeen = wrSeen | mem_wr;
      end else begin
        enCnt  = 0;
        wrSeen = 1'b0;
      end
    end
    dPrev = d_done;
    iPrev = if_done;
  end

  task automatic dataOp(input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] ex,
                        input logic chk);
    bit ok = 0;
    dq.push_back({chk, ex});
    d_wr = wr;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (d_done) begin
        ok = 1;
        break;
      end
    end
    d_req = 1'b0;
    if (!ok) check("d_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetchOp(input logic [15:0] a, input logic [15:0] ex);
    bit ok = 0;
    iq.push_back({1'b1, ex});
    if_addr = a;
    if_req = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (if_done) begin
        ok = 1;
        break;
      end
    end
    if_req = 1'b0;
    if (!ok) check("if_timeout", 32'd0, 32'd1);
  endtask

  task automatic seqClr();
    seqBits = '0;
    seqLen = 0;
  endtask

  task automatic seqChk(input string nm, input int n,
                        input logic [31:0] bits);
    check({nm, "_len"}, 32'(seqLen), 32'(n));
    check({nm, "_order"}, seqBits, bits);
  endtask

  task automatic allZero(input string nm);
    check({nm, "_mem_en"}, 32'(mem_en), 32'd0);
    check({nm, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({nm, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({nm, "_if_done"}, 32'(if_done), 32'd0);
    check({nm, "_d_done"}, 32'(d_done), 32'd0);
    check({nm, "_if_rdata"}, 32'(if_rdata), 32'd0);
    check({nm, "_d_rdata"}, 32'(d_rdata), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    d_req = 1'b0;
    d_wr = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    repeat (3) @(negedge clk);
    allZero("reset");
`ifdef MEM_ARB_PERF_EN
    check("reset_perf_if", 32'(perf_if_grants), 32'd0);
    check("reset_perf_d", 32'(perf_d_grants), 32'd0);
    check("reset_perf_stall", 32'(perf_stall_cyc), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // simultaneous store + fetch: data first
    seqClr();
    fork
      dataOp(1'b1, 16'h0040, 16'h1234, 16'h0000, 1'b0);
      fetchOp(16'h0020, 16'hA585);
    join
    repeat (2) @(negedge clk);
    seqChk("both", 2, 32'b10);
    check("store_word40", 32'(mem[16'h0040]), 32'h1234);
`ifdef MEM_ARB_PERF_EN
    check("perf_if_grants", 32'(perf_if_grants), 32'd1);
    check("perf_d_grants", 32'(perf_d_grants), 32'd1);
    check("perf_stall_cyc", 32'(perf_stall_cyc), 32'd5);
`endif

    // lone fetch
    seqClr();
    fetchOp(16'h0010, 16'hA5B5);
    @(negedge clk);
    seqChk("fetch_only", 1, 32'b0);

    // starvation limit
    seqClr();
    fork
      begin
        dataOp(1'b0, 16'h0100, 16'h0, 16'hA4A5, 1'b1);
        dataOp(1'b0, 16'h0101, 16'h0, 16'hA4A4, 1'b1);
        dataOp(1'b0, 16'h0102, 16'h0, 16'hA4A7, 1'b1);
        dataOp(1'b0, 16'h0103, 16'h0, 16'hA4A6, 1'b1);
        dataOp(1'b0, 16'h0104, 16'h0, 16'hA4A1, 1'b1);
      end
      fetchOp(16'h0200, 16'hA7A5);
    join
    @(negedge clk);
    seqChk("starve", 6, 32'b111101);

    // load then fetch: d_rdata holds
    dataOp(1'b0, 16'h00FF, 16'h0, 16'hA55A, 1'b1);
    fetchOp(16'h0011, 16'hA5B4);
    @(negedge clk);
    check("d_rdata_hold", 32'(d_rdata), 32'hA55A);

    // reset in 2nd cycle of a store
    d_wr = 1'b1;
    d_addr = 16'h0050;
    d_wdata = 16'hBEEF;
    d_req = 1'b1;
    @(negedge clk);
    check("abort_en_cycle1", 32'(mem_en), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    allZero("abort");
    d_req = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_write", 32'(mem[16'h0050]), 32'hA5F5);
    rst_n = 1'b1;
    @(negedge clk);
    seqClr();
    fork
      dataOp(1'b0, 16'h0060, 16'h0, 16'hA5C5, 1'b1);
      fetchOp(16'h0061, 16'hA5C4);
    join
    @(negedge clk);
    seqChk("post_reset", 2, 32'b10);
    check("dq_empty", 32'(dq.size()), 32'd0);
    check("iq_empty", 32'(iq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
